gf_reduce_seq: RTL
==================

// Module: gf_reduce_seq
// PURPOSE
//  Sequential GF(2^m) modular reducer; sits directly downstream of the carry-less adder/multiplier array.
//  Consumes its 2*DATA_WIDTH-bit carry-less product and reduces it modulo x^m + poly.
//  Produces the DATA_WIDTH-bit field element. Bit-serial: one high-order bit cleared per clock.
//  Uses valid/ready handshakes on both sides.
// PARAMETERS
//  DATA_WIDTH  32  field degree m; width of result and poly; product input is 2*DATA_WIDTH
// PORTS
//  clk        in   1             clock
//  rst_n      in   1             synchronous, active-low reset
//  in_valid   in   1             prod/poly valid
//  in_ready   out  1             reducer can accept; high only in IDLE
//  prod       in   2*DATA_WIDTH  carry-less product to reduce (mult_out of the upstream array)
//  poly       in   DATA_WIDTH    low coefficients of modulus; x^m term implicit
//  out_valid  out  1             result valid; held until accepted
//  out_ready  in   1             consumer accepts result
//  out_data   out  DATA_WIDTH    prod mod (x^m + poly)
//  busy       out  1             state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, out_valid=0, out_data=0, busy=0, in_ready=1 after reset.
//    Work registers are cleared.
//  Reset mid-operation: the in-flight job is discarded; no out_valid pulse; IDLE on the next cycle.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid: latch r<=prod, p<=poly, cnt<=2*DATA_WIDTH-1; go RUN.
//  RUN: if r[cnt]=1 then r <= r ^ ({1'b1,p} << (cnt-DATA_WIDTH)).
//    cnt decrements each cycle.
//    When the processed cnt == DATA_WIDTH, go DONE, out_data <= r[DATA_WIDTH-1:0] (post-step value).
//  DONE: out_valid=1. out_data is stable while out_ready=0.
//    On out_ready, go IDLE and drop out_valid at the next edge.
//  Latency: out_valid rises exactly DATA_WIDTH edges after the accepting edge.
//    Throughput is one job per DATA_WIDTH+2 cycles; there is no accept/complete overlap.
//  poly and prod are sampled only at accept; later changes on the ports are ignored.
//  in_valid while busy is ignored; the source must hold it.
//  Bit 2*DATA_WIDTH-1 is processed too, so integer (carry) products are still reduced as polynomials.
//  cnt width is $clog2(2*DATA_WIDTH); no wrap, since RUN exits at cnt==DATA_WIDTH.
//  poly=0 is legal: the modulus is x^m and the result is prod[DATA_WIDTH-1:0].
// CONFIGURATION
//  GF_REDUCE_EARLY_EXIT_EN defined:
//    In RUN, if r[2*DATA_WIDTH-1:cnt+1]... more simply, if r[2*DATA_WIDTH-1:DATA_WIDTH]==0,
//    go DONE at the next edge without further steps.
//    Latency is variable, 1..DATA_WIDTH edges; an input whose high half is already zero completes after 1 edge.
//  Undefined: fixed latency DATA_WIDTH, regardless of data.
// STRUCTURE
//  Shared header gf_defs.vh: FSM state encodings (GF_ST_IDLE/RUN/DONE, 2 bits) and the
//    AES modulus constant GF8_POLY_AES=8'h1B, reused by other field blocks.
//  One combinational sub-module, gf_reduce_step #(DATA_WIDTH) (r, p, idx -> r_next),
//    implements a single conditional shift-XOR.
//  The top level holds the FSM, counter and registers.
// TESTING (DATA_WIDTH=8, poly=8'h1B unless stated)
//  1. prod=16'h2B79 (0x57*0x83 carry-less) -> out_data=8'hC1; out_valid 8 edges after accept.
//  2. prod=16'h0100 -> 8'h1B. prod=16'h0080 -> 8'h80. prod=16'h8000 -> x^15 mod AES poly = 8'h1B^... check vs model.
//  3. Backpressure: hold out_ready=0 for 5 cycles after out_valid.
//     out_data stays constant, in_ready=0; a new in_valid is not accepted until 1 cycle after the handshake.
//  4. Reset: drop rst_n for 1 cycle at cycle 3 of RUN.
//     No out_valid; in_ready=1 next cycle; the next job (prod=16'h2B79) gives 8'hC1.
//  5. Port change: alter poly/prod during RUN. The result still matches the values latched at accept.
//  6. Random 1k jobs, poly in {1B, 1D, 00}, checked against a software model.
//     With GF_REDUCE_EARLY_EXIT_EN: prod=16'h00FF -> 8'hFF after 1 edge.

Source files
------------

// File: rtl/gf_reduce_seq_pkg.sv
// Shared definitions for the GF(2^m) reducer: FSM state encodings and field constants.
package gf_reduce_seq_pkg;

    typedef enum logic [1:0] {
        GF_ST_IDLE = 2'd0,
        GF_ST_RUN  = 2'd1,
        GF_ST_DONE = 2'd2
    } gf_state_t;

    // AES field modulus x^8 + x^4 + x^3 + x + 1, low coefficients only.
    localparam logic [7:0] GF8_POLY_AES = 8'h1B;

endpackage

// File: rtl/gf_reduce_seq_step.sv
// One conditional shift-XOR of the bit-serial GF(2^m) reduction.
module gf_reduce_seq_step
    import gf_reduce_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH-1:0]         r,
    input  logic [DATA_WIDTH-1:0]           p,
    input  logic [$clog2(2*DATA_WIDTH)-1:0] idx,
    output logic [2*DATA_WIDTH-1:0]         r_next
);

    localparam int CNT_W = $clog2(2*DATA_WIDTH);

    logic [2*DATA_WIDTH-1:0] divisor;
    logic [CNT_W-1:0]        shamt;

    // Aligning x^m with bit idx cancels that bit; idx never drops below DATA_WIDTH here.
    always_comb begin
        divisor = {{(DATA_WIDTH-1){1'b0}}, 1'b1, p};
        shamt   = idx - CNT_W'(DATA_WIDTH);
        r_next  = r;
        if (r[idx]) begin
            r_next = r ^ (divisor << shamt);
        end
    end

endmodule

// File: rtl/gf_reduce_seq.sv
// Sequential GF(2^m) reducer: clears one high-order product bit per clock, valid/ready on both sides.
// Optional GF_REDUCE_EARLY_EXIT_EN: finish as soon as the upper half of the work register is zero.
module gf_reduce_seq
    import gf_reduce_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] prod,
    input  logic [DATA_WIDTH-1:0]   poly,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    busy
);

    localparam int PROD_W = 2*DATA_WIDTH;
    localparam int CNT_W  = $clog2(PROD_W);

    gf_state_t               state_q, state_d;
    logic [PROD_W-1:0]       r_q, r_d, r_step;
    logic [DATA_WIDTH-1:0]   p_q, p_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    last_step;

    gf_reduce_seq_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .r      (r_q),
        .p      (p_q),
        .idx    (cnt_q),
        .r_next (r_step)
    );

`ifdef GF_REDUCE_EARLY_EXIT_EN
    // Nothing left above bit m-1 means the low half already is the residue.
    assign last_step = (cnt_q == CNT_W'(DATA_WIDTH)) || (r_q[PROD_W-1:DATA_WIDTH] == '0);
`else
    assign last_step = (cnt_q == CNT_W'(DATA_WIDTH));
`endif

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        p_d        = p_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        case (state_q)
            GF_ST_IDLE: begin
                if (in_valid) begin
                    r_d     = prod;
                    p_d     = poly;
                    cnt_d   = CNT_W'(PROD_W-1);
                    state_d = GF_ST_RUN;
                end
            end
            GF_ST_RUN: begin
                r_d   = r_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (last_step) begin
                    out_data_d = r_step[DATA_WIDTH-1:0];
                    state_d    = GF_ST_DONE;
                end
            end
            GF_ST_DONE: begin
                if (out_ready) begin
                    state_d = GF_ST_IDLE;
                end
            end
            default: begin
                state_d = GF_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= GF_ST_IDLE;
            r_q        <= '0;
            p_q        <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            p_q        <= p_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

    assign in_ready  = (state_q == GF_ST_IDLE);
    assign out_valid = (state_q == GF_ST_DONE);
    assign busy      = (state_q != GF_ST_IDLE);
    assign out_data  = out_data_q;

endmodule
